uop_encode: RTL and testbench

UOP_ENCODE -- requirements
Module: uop_encode

---
 rtl/uop_encode_pkg.sv | 47 ++++
 rtl/imm_pack.sv | 121 ++++++++++++
 rtl/uop_encode.sv | 79 +++++++
 tb/tb_uop_encode.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uop_encode_pkg.sv
// uop_encode_pkg: immediate-type and micro-opcode packages plus the shared rv32i_types
// package (opcodes, uop record, packed-immediate decoder) used by uop_encode.
package immt;
    typedef enum logic [2:0] {i, s, b, u, j} imm_type_t;
endpackage

package uopc;
    typedef enum logic [5:0] {
        lui, auipc, jal, jalr,
        beq, bne, blt, bge, bltu, bgeu,
        lb, lh, lw, lbu, lhu,
        sb, sh, sw,
        addi, slti, sltiu, xori, ori, andi, slli, srli, srai,
        add, sub, sll, slt, sltu, xoro, srl, sra, oro, ando
    } micro_opcode_t;
endpackage

package rv32i_types;
    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    typedef struct packed {
        uopc::micro_opcode_t uopcode;
        immt::imm_type_t     imm_type;
        logic [19:0]         packed_imm;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         pc;
        logic                illegal;
    } uop_t;

    // Rebuilds the full 32-bit immediate from the 20-bit packed form.
    function automatic logic [31:0] imm_dec(input logic [19:0] p, input immt::imm_type_t t);
        return t == immt::u ? {p, 12'h000} :
               t == immt::j ? {{12{p[19]}}, p[7:0], p[8], p[18:13], p[12:9], 1'b0} :
               t == immt::b ? {{20{p[19]}}, p[8], p[18:13], p[12:9], 1'b0} :
                              {{21{p[19]}}, p[18:8]};
    endfunction
endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational RV32I decode into a micro-opcode, register fields and a
// 20-bit packed immediate; unknown encodings become an illegal addi with zero immediate.
module imm_pack
    import rv32i_types::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output uop_t        uop
);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [19:0] i_imm;
    logic        ill;

    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign i_imm = {inst[31:20], 8'h00};

    always_comb begin
        uop      = '0;
        uop.rd   = inst[11:7];
        uop.rs1  = inst[19:15];
        uop.rs2  = inst[24:20];
        uop.pc   = pc;
        uop.imm_type = immt::i;
        ill      = 1'b0;
        case (inst[6:0])
            op_lui: begin
                uop.uopcode    = uopc::lui;
                uop.imm_type   = immt::u;
                uop.packed_imm = inst[31:12];
            end
            op_auipc: begin
                uop.uopcode    = uopc::auipc;
                uop.imm_type   = immt::u;
                uop.packed_imm = inst[31:12];
            end
            // The J-type packed layout lines up bit-for-bit with inst[31:12].
            op_jal: begin
                uop.uopcode    = uopc::jal;
                uop.imm_type   = immt::j;
                uop.packed_imm = inst[31:12];
            end
            op_jalr: begin
                uop.uopcode    = uopc::jalr;
                uop.packed_imm = i_imm;
                ill            = f3 != 3'd0;
            end
            op_br: begin
                case (f3)
                    3'd0:    uop.uopcode = uopc::beq;
                    3'd1:    uop.uopcode = uopc::bne;
                    3'd4:    uop.uopcode = uopc::blt;
                    3'd5:    uop.uopcode = uopc::bge;
                    3'd6:    uop.uopcode = uopc::bltu;
                    default: uop.uopcode = uopc::bgeu;
                endcase
                uop.imm_type   = immt::b;
                uop.packed_imm = {inst[31:25], inst[11:8], inst[7], 8'h00};
                uop.rd         = '0;
                ill            = f3[2:1] == 2'b01;
            end
            op_load: begin
                case (f3)
                    3'd0:    uop.uopcode = uopc::lb;
                    3'd1:    uop.uopcode = uopc::lh;
                    3'd2:    uop.uopcode = uopc::lw;
                    3'd4:    uop.uopcode = uopc::lbu;
                    default: uop.uopcode = uopc::lhu;
                endcase
                uop.packed_imm = i_imm;
                ill            = f3 == 3'd3 || f3[2:1] == 2'b11;
            end
            op_store: begin
                case (f3)
                    3'd0:    uop.uopcode = uopc::sb;
                    3'd1:    uop.uopcode = uopc::sh;
                    default: uop.uopcode = uopc::sw;
                endcase
                uop.imm_type   = immt::s;
                uop.packed_imm = {inst[31:25], inst[11:7], 8'h00};
                uop.rd         = '0;
                ill            = f3[2] || f3 == 3'd3;
            end
            op_imm: begin
                case (f3)
                    3'd0:    uop.uopcode = uopc::addi;
                    3'd1:    uop.uopcode = uopc::slli;
                    3'd2:    uop.uopcode = uopc::slti;
                    3'd3:    uop.uopcode = uopc::sltiu;
                    3'd4:    uop.uopcode = uopc::xori;
                    3'd5:    uop.uopcode = f7[5] ? uopc::srai : uopc::srli;
                    3'd6:    uop.uopcode = uopc::ori;
                    default: uop.uopcode = uopc::andi;
                endcase
                uop.packed_imm = i_imm;
                ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            op_reg: begin
                case (f3)
                    3'd0:    uop.uopcode = f7[5] ? uopc::sub : uopc::add;
                    3'd1:    uop.uopcode = uopc::sll;
                    3'd2:    uop.uopcode = uopc::slt;
                    3'd3:    uop.uopcode = uopc::sltu;
                    3'd4:    uop.uopcode = uopc::xoro;
                    3'd5:    uop.uopcode = f7[5] ? uopc::sra : uopc::srl;
                    3'd6:    uop.uopcode = uopc::oro;
                    default: uop.uopcode = uopc::ando;
                endcase
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            uop.uopcode    = uopc::addi;
            uop.imm_type   = immt::i;
            uop.packed_imm = '0;
            uop.illegal    = 1'b1;
        end
    end
endmodule

// File: rtl/uop_encode.sv
// uop_encode: one-cycle valid/ready stage around imm_pack. Define UOP_ENCODE_SKID_EN
// for a 2-entry (main + skid) output stage with a registered in_ready.
module uop_encode
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [31:0]         in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output uopc::micro_opcode_t out_uopcode,
    output immt::imm_type_t     out_imm_type,
    output logic [19:0]         out_packed_imm,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [31:0]         out_pc,
    output logic                out_illegal,
    input  logic                flush
);
    uop_t dec;
    uop_t main_q;

    imm_pack u_pack (.inst(in_inst), .pc(in_pc), .uop(dec));

    assign out_uopcode    = main_q.uopcode;
    assign out_imm_type   = main_q.imm_type;
    assign out_packed_imm = main_q.packed_imm;
    assign out_rd         = main_q.rd;
    assign out_rs1        = main_q.rs1;
    assign out_rs2        = main_q.rs2;
    assign out_pc         = main_q.pc;
    assign out_illegal    = main_q.illegal;

`ifdef UOP_ENCODE_SKID_EN
    uop_t skid_q;
    logic skid_valid;

    assign in_ready = !skid_valid;

    // While the main entry is stalled, one more accepted word parks in skid_q;
    // it moves to main the first cycle the consumer frees the main entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_valid  <= skid_valid || in_valid;
            main_q     <= skid_valid ? skid_q : in_valid ? dec : main_q;
            skid_valid <= 1'b0;
        end else if (in_valid && !skid_valid) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            main_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            main_q    <= in_valid ? dec : main_q;
        end
    end
`endif
endmodule

// File: tb/tb_uop_encode.sv
// tb_uop_encode: scoreboard bench for uop_encode; expected uops are queued on input
// handshakes and popped on output handshakes. Honours UOP_ENCODE_SKID_EN.
module tb_uop_encode;
    import rv32i_types::*;

`ifdef UOP_ENCODE_SKID_EN
    localparam bit skid = 1'b1;
`else
    localparam bit skid = 1'b0;
`endif
    localparam int nv = 20;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, flush, out_illegal;
    logic [31:0] in_inst, in_pc, out_pc;
    uopc::micro_opcode_t out_uopcode;
    immt::imm_type_t out_imm_type;
    logic [19:0] out_packed_imm;
    logic [4:0] out_rd, out_rs1, out_rs2;

    typedef struct {
        logic [31:0]         inst;
        uopc::micro_opcode_t uop;
        immt::imm_type_t     ty;
        logic [19:0]         pk;
        logic [4:0]          rd;
        logic                ill;
        logic [31:0]         pc;
    } vec_t;

    vec_t vecs[nv];
    vec_t exp_q[$];
    vec_t cur, mon_e;
    int mon_cmp = 0, mon_err = 0, t_cmp = 0, t_err = 0;
    int vi = 0, stream_cycles = 0;

    always #5 clk = ~clk;

    uop_encode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_uopcode(out_uopcode), .out_imm_type(out_imm_type),
        .out_packed_imm(out_packed_imm), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_pc(out_pc), .out_illegal(out_illegal), .flush(flush)
    );

    function automatic logic [31:0] isa_imm(input logic [31:0] x);
        case (x[6:0])
            7'b0110111, 7'b0010111: return {x[31:12], 12'h000};
            7'b1101111: return {{12{x[31]}}, x[19:12], x[20], x[30:21], 1'b0};
            7'b1100011: return {{20{x[31]}}, x[7], x[30:25], x[11:8], 1'b0};
            7'b0100011: return {{21{x[31]}}, x[30:25], x[11:7]};
            7'b0110011: return 32'h0;
            default:    return {{21{x[31]}}, x[30:20]};
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst || flush) exp_q.delete();
        else begin
            if (out_valid && out_ready) begin
                mon_cmp++;
                if (exp_q.size() == 0) begin
                    mon_err++;
                    $display("FAIL sb_unexpected: got output pc=%h uop=%0d, required no output", out_pc, out_uopcode);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({out_uopcode, out_imm_type, out_packed_imm, out_rd, out_rs1, out_rs2, out_pc, out_illegal} !==
                        {mon_e.uop, mon_e.ty, mon_e.pk, mon_e.rd, mon_e.inst[19:15], mon_e.inst[24:20], mon_e.pc, mon_e.ill}) begin
                        mon_err++;
                        $display("FAIL sb_fields inst=%h: got uop=%0d ty=%0d pk=%h rd=%0d rs1=%0d rs2=%0d pc=%h ill=%b, required uop=%0d ty=%0d pk=%h rd=%0d rs1=%0d rs2=%0d pc=%h ill=%b",
                                 mon_e.inst, out_uopcode, out_imm_type, out_packed_imm, out_rd, out_rs1, out_rs2, out_pc, out_illegal,
                                 mon_e.uop, mon_e.ty, mon_e.pk, mon_e.rd, mon_e.inst[19:15], mon_e.inst[24:20], mon_e.pc, mon_e.ill);
                    end
                    if (!mon_e.ill) begin
                        mon_cmp++;
                        if (imm_dec(out_packed_imm, out_imm_type) !== isa_imm(mon_e.inst)) begin
                            mon_err++;
                            $display("FAIL round_trip inst=%h: got %h, required %h", mon_e.inst,
                                     imm_dec(out_packed_imm, out_imm_type), isa_imm(mon_e.inst));
                        end
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur);
        end
    end

    task automatic drive(input int k);
        cur = vecs[k];
        cur.pc = $urandom & 32'hFFFF_FFFC;
        in_inst = cur.inst;
        in_pc = cur.pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n, input int pv, input int pr);
        int sent = 0, cyc = 0;
        logic acc;
        in_valid = $urandom_range(99) < pv;
        out_ready = $urandom_range(99) < pr;
        drive(vi % nv);
        while (sent < n && cyc < 2000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                sent++;
                vi++;
            end
            in_valid = $urandom_range(99) < pv;
            out_ready = $urandom_range(99) < pr;
            drive(vi % nv);
        end
        in_valid = 1'b0;
        stream_cycles = cyc;
        t_cmp++;
        if (sent != n) begin
            t_err++;
            $display("FAIL stream_budget: got %0d accepted, required %0d", sent, n);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        tick();
    endtask

    task automatic fill(input int n);
        logic acc;
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(vi % nv);
        repeat (n) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                vi++;
                drive(vi % nv);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
        #3;
        t_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {out_uopcode, out_imm_type, out_packed_imm, out_rd, out_rs1, out_rs2, out_pc, out_illegal} !== '0) begin
            t_err++;
            $display("FAIL reset_values: got valid=%b ready=%b pk=%h pc=%h uop=%0d, required 0 1 0 0 0",
                     out_valid, in_ready, out_packed_imm, out_pc, out_uopcode);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid = 1'b1;
        drive(0);
        tick();
        in_valid = 1'b0;
        t_cmp++;
        if (out_valid !== 1'b1 || out_uopcode !== uopc::addi || out_imm_type !== immt::i ||
            out_packed_imm !== 20'hFFF00 || out_rd !== 5'd1) begin
            t_err++;
            $display("FAIL latency_addi: got valid=%b uop=%0d ty=%0d pk=%h rd=%0d, required 1 %0d %0d fff00 1",
                     out_valid, out_uopcode, out_imm_type, out_packed_imm, out_rd, uopc::addi, immt::i);
        end
        tick();
        t_cmp++;
        if (out_valid !== 1'b0) begin
            t_err++;
            $display("FAIL latency_idle: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        vi = 0;
        run_stream(nv, 100, 100);
        t_cmp++;
        if (stream_cycles != nv) begin
            t_err++;
            $display("FAIL back_to_back_cycles: got %0d, required %0d", stream_cycles, nv);
        end
        drain();
        t_cmp++;
        if (exp_q.size() != 0) begin
            t_err++;
            $display("FAIL back_to_back_lost: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic acc, exp_rdy;
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(vi % nv);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            exp_rdy = skid ? (k < 2) : (k < 1);
            t_cmp++;
            if (in_ready !== exp_rdy) begin
                t_err++;
                $display("FAIL stall_in_ready cycle %0d: got %b, required %b", k, in_ready, exp_rdy);
            end
            tick();
            if (acc) begin
                vi++;
                drive(vi % nv);
            end
        end
        run_stream(6, 100, 100);
        drain();
        t_cmp++;
        if (exp_q.size() != 0) begin
            t_err++;
            $display("FAIL stall_lost: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        run_stream(40, 70, 60);
        drain();
        t_cmp++;
        if (exp_q.size() != 0) begin
            t_err++;
            $display("FAIL random_lost: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        fill(3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        t_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            t_err++;
            $display("FAIL flush_clear: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (4) tick();
        t_cmp++;
        if (out_valid !== 1'b0) begin
            t_err++;
            $display("FAIL flush_residue: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        fill(3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        t_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
            t_err++;
            $display("FAIL reset_mid: got valid=%b ready=%b pc=%h, required 0 1 0", out_valid, in_ready, out_pc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) tick();
        t_cmp++;
        if (out_valid !== 1'b0) begin
            t_err++;
            $display("FAIL reset_mid_pulse: got valid=%b, required 0", out_valid);
        end
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, uopc::addi,  immt::i, 20'hFFF00, 5'd1, 1'b0, 32'h0};
        vecs[1]  = '{32'h001000EF, uopc::jal,   immt::j, 20'h00100, 5'd1, 1'b0, 32'h0};
        vecs[2]  = '{32'h800002B7, uopc::lui,   immt::u, 20'h80000, 5'd5, 1'b0, 32'h0};
        vecs[3]  = '{32'h80000063, uopc::beq,   immt::b, 20'h80000, 5'd0, 1'b0, 32'h0};
        vecs[4]  = '{32'h00209463, uopc::bne,   immt::b, 20'h00800, 5'd0, 1'b0, 32'h0};
        vecs[5]  = '{32'hFE512E23, uopc::sw,    immt::s, 20'hFFC00, 5'd0, 1'b0, 32'h0};
        vecs[6]  = '{32'h0100A183, uopc::lw,    immt::i, 20'h01000, 5'd3, 1'b0, 32'h0};
        vecs[7]  = '{32'hFFF04203, uopc::lbu,   immt::i, 20'hFFF00, 5'd4, 1'b0, 32'h0};
        vecs[8]  = '{32'h402081B3, uopc::sub,   immt::i, 20'h00000, 5'd3, 1'b0, 32'h0};
        vecs[9]  = '{32'h022081B3, uopc::addi,  immt::i, 20'h00000, 5'd3, 1'b1, 32'h0};
        vecs[10] = '{32'h0000007F, uopc::addi,  immt::i, 20'h00000, 5'd0, 1'b1, 32'h0};
        vecs[11] = '{32'h4030D093, uopc::srai,  immt::i, 20'h40300, 5'd1, 1'b0, 32'h0};
        vecs[12] = '{32'h40309093, uopc::addi,  immt::i, 20'h00000, 5'd1, 1'b1, 32'h0};
        vecs[13] = '{32'h12345397, uopc::auipc, immt::u, 20'h12345, 5'd7, 1'b0, 32'h0};
        vecs[14] = '{32'h004100E7, uopc::jalr,  immt::i, 20'h00400, 5'd1, 1'b0, 32'h0};
        vecs[15] = '{32'h004110E7, uopc::addi,  immt::i, 20'h00000, 5'd1, 1'b1, 32'h0};
        vecs[16] = '{32'h007372B3, uopc::ando,  immt::i, 20'h00000, 5'd5, 1'b0, 32'h0};
        vecs[17] = '{32'hFE20FFE3, uopc::bgeu,  immt::b, 20'hFFF00, 5'd0, 1'b0, 32'h0};
        vecs[18] = '{32'hFFFFF06F, uopc::jal,   immt::j, 20'hFFFFF, 5'd0, 1'b0, 32'h0};
        vecs[19] = '{32'h7FF14093, uopc::xori,  immt::i, 20'h7FF00, 5'd1, 1'b0, 32'h0};
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_random();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", t_cmp + mon_cmp, t_err + mon_err);
        $finish;
    end
endmodule
